spiflash_responder: RTL and testbench

//  Synthesizable SPI-mode-0 flash responder: the device end of the single-lane flash link the

---
 rtl/spiflash_responder.sv | 158 +++++++++++++++
 tb/tb_spiflash_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_responder.sv
// rtl/spiflash_responder.sv - SPI mode-0 flash device model streaming bytes from a synchronous byte memory
module spiflash_responder #(
    parameter int          ADDR_BITS          = 24,
    parameter logic [23:0] JEDEC_ID           = 24'hEF4016,
    parameter bit          START_POWERED_DOWN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_csb,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic                 mem_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 powered_down
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_WAKE, S_SLEEP, S_IGNORE
    } state_t;

    state_t      state, state_next;
    logic [2:0]  csb_q, sclk_q;
    logic [1:0]  mosi_q;
    logic [22:0] shift_in;
    logic [23:0] shift_next;
    logic [4:0]  bit_cnt;
    logic [2:0]  out_pos;
    logic [7:0]  out_shift, prefetch, byte_src;
    logic [1:0]  id_idx;
    logic        rd_pending;
    logic        csb_rise, csb_fall, sclk_rise, sclk_fall, launch;

    // Edges are taken between the second and third flop so every event sees settled mosi.
    assign csb_rise   =  csb_q[1]  & ~csb_q[2];
    assign csb_fall   = ~csb_q[1]  &  csb_q[2];
    assign sclk_rise  =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall  = ~sclk_q[1] &  sclk_q[2];
    assign shift_next = {shift_in, mosi_q[1]};
    assign launch     = sclk_fall && (state == S_DATA || state == S_ID ||
                                      (state == S_ADDR && bit_cnt == 5'd24));

    always_comb begin
        byte_src = prefetch;
        if (state == S_ID) begin
            case (id_idx)
                2'd0:    byte_src = JEDEC_ID[23:16];
                2'd1:    byte_src = JEDEC_ID[15:8];
                2'd2:    byte_src = JEDEC_ID[7:0];
                default: byte_src = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (csb_rise) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (csb_fall) state_next = S_CMD;
                S_CMD: begin
                    if (sclk_rise && bit_cnt == 5'd7) begin
                        case (shift_next[7:0])
                            8'h03:   state_next = powered_down ? S_IGNORE : S_ADDR;
                            8'h9F:   state_next = powered_down ? S_IGNORE : S_ID;
                            8'hAB:   state_next = S_WAKE;
                            8'hB9:   state_next = powered_down ? S_IGNORE : S_SLEEP;
                            default: state_next = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: if (sclk_fall && bit_cnt == 5'd24) state_next = S_DATA;
                S_WAKE, S_SLEEP: if (sclk_rise) state_next = S_IGNORE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csb_q        <= 3'b111;
            sclk_q       <= 3'b000;
            mosi_q       <= 2'b00;
            shift_in     <= '0;
            bit_cnt      <= '0;
            out_pos      <= '0;
            out_shift    <= '0;
            prefetch     <= '0;
            id_idx       <= '0;
            rd_pending   <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            mem_en       <= 1'b0;
            mem_addr     <= '0;
            powered_down <= START_POWERED_DOWN;
        end else begin
            csb_q      <= {csb_q[1:0], spi_csb};
            sclk_q     <= {sclk_q[1:0], spi_sclk};
            mosi_q     <= {mosi_q[0], spi_mosi};
            mem_en     <= 1'b0;
            rd_pending <= mem_en;
            if (rd_pending) prefetch <= mem_rdata;

            if (csb_rise) begin
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                bit_cnt     <= '0;
                out_pos     <= '0;
                if (state == S_WAKE)  powered_down <= 1'b0;
                if (state == S_SLEEP) powered_down <= 1'b1;
            end else begin
                if (state == S_IDLE && csb_fall) begin
                    bit_cnt <= '0;
                    out_pos <= '0;
                    id_idx  <= '0;
                end
                if (sclk_rise && (state == S_CMD || state == S_ADDR) && bit_cnt != 5'd24) begin
                    shift_in <= shift_next[22:0];
                    bit_cnt  <= (state == S_CMD && bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                end
                if (sclk_rise && state == S_ADDR && bit_cnt == 5'd23) begin
                    mem_addr <= shift_next[ADDR_BITS-1:0];
                    mem_en   <= 1'b1;
                end
                // Byte boundary: emit the held byte and fetch its successor for the next boundary.
                if (launch) begin
                    if (out_pos == 3'd0) begin
                        spi_miso    <= byte_src[7];
                        out_shift   <= {byte_src[6:0], 1'b0};
                        spi_miso_oe <= 1'b1;
                        if (state == S_ID) begin
                            id_idx <= (id_idx == 2'd3) ? 2'd3 : id_idx + 2'd1;
                        end else begin
                            mem_addr <= mem_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                            mem_en   <= 1'b1;
                        end
                    end else begin
                        spi_miso  <= out_shift[7];
                        out_shift <= {out_shift[6:0], 1'b0};
                    end
                    out_pos <= out_pos + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spiflash_responder.sv
// tb/tb_spiflash_responder.sv - randomized self-checking bench for spiflash_responder
module tb_spiflash_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spi_csb = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
    logic        miso_a, oe_a, en_a, pd_a, miso_b, oe_b, en_b, pd_b;
    logic [23:0] addr_a;
    logic [15:0] addr_b;
    logic [7:0]  rdata_a = 8'h00, rdata_b = 8'h00;

    int          n_checks = 0, n_errors = 0, viol = 0;
    logic        oe_seen = 1'b0;
    logic [23:0] mq_a[$];
    logic [15:0] mq_b[$];

    always #5 clk = ~clk;

    spiflash_responder dut_a (
        .clk(clk), .reset(reset), .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(miso_a), .spi_miso_oe(oe_a), .mem_en(en_a), .mem_addr(addr_a),
        .mem_rdata(rdata_a), .powered_down(pd_a)
    );

    spiflash_responder #(.ADDR_BITS(16)) dut_b (
        .clk(clk), .reset(reset), .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(miso_b), .spi_miso_oe(oe_b), .mem_en(en_b), .mem_addr(addr_b),
        .mem_rdata(rdata_b), .powered_down(pd_b)
    );

    // Backing memory contents as a pure function of the address.
    function automatic logic [7:0] mem_f(input logic [23:0] a);
        return (a[7:0] ^ 8'h5A) + a[15:8] + a[23:16];
    endfunction

    always @(posedge clk) begin
        if (en_a) begin rdata_a <= mem_f(addr_a); mq_a.push_back(addr_a); end
        if (en_b) begin rdata_b <= mem_f({8'h00, addr_b}); mq_b.push_back(addr_b); end
        if ((en_a && pd_a) || (en_b && pd_b)) viol++;
        if ((!oe_a && miso_a) || (!oe_b && miso_b)) viol++;
        if (oe_a || oe_b) oe_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_csb = 1'b0;
        ticks(6);
    endtask

    task automatic cs_high();
        spi_sclk = 1'b0;
        ticks(6);
        spi_csb = 1'b1;
        ticks(5);
        check("oe_drop_a", {31'd0, oe_a}, 32'd0);
        check("oe_drop_b", {31'd0, oe_b}, 32'd0);
        ticks(4);
    endtask

    task automatic xfer(input logic [31:0] v, input int nb,
                        output logic [31:0] ra, output logic [31:0] rb);
        ra = '0;
        rb = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            ticks(6);
            ra = {ra[30:0], miso_a};
            rb = {rb[30:0], miso_b};
            spi_sclk = 1'b1;
            ticks(6);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic command(input logic [31:0] v, input int nb);
        logic [31:0] ra, rb;
        cs_low();
        xfer(v, nb, ra, rb);
        cs_high();
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [31:0] ra, rb;
        logic [23:0] ea;
        logic [15:0] eb;
        mq_a.delete();
        mq_b.delete();
        cs_low();
        xfer(32'h03, 8, ra, rb);
        xfer({8'h00, a}, 24, ra, rb);
        for (int i = 0; i < n; i++) begin
            ea = a + 24'(i);
            eb = a[15:0] + 16'(i);
            xfer(32'h0, 8, ra, rb);
            check("rd_data_a", ra, {24'h0, mem_f(ea)});
            check("rd_data_b", rb, {24'h0, mem_f({8'h00, eb})});
        end
        cs_high();
        check("mq_len_a", {31'd0, mq_a.size() >= n && mq_a.size() <= n + 2}, 32'd1);
        check("mq_len_b", {31'd0, mq_b.size() >= n && mq_b.size() <= n + 2}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i < mq_a.size()) check("rd_addr_a", {8'h0, mq_a[i]}, {8'h0, a + 24'(i)});
            if (i < mq_b.size()) check("rd_addr_b", {16'h0, mq_b[i]}, {16'h0, a[15:0] + 16'(i)});
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [23:0] jedec;

        reset = 1'b1;
        ticks(3);
        check("rst_miso", {30'd0, miso_a, miso_b}, 32'd0);
        check("rst_oe", {30'd0, oe_a, oe_b}, 32'd0);
        check("rst_en", {30'd0, en_a, en_b}, 32'd0);
        check("rst_addr", {addr_a, 8'h0} | {16'h0, addr_b}, 32'd0);
        check("rst_pd", {30'd0, pd_a, pd_b}, 32'd3);
        reset = 1'b0;
        ticks(4);

        // Read while powered down is ignored.
        mq_a.delete(); mq_b.delete(); oe_seen = 1'b0;
        cs_low();
        xfer(32'h03, 8, ra, rb);
        xfer(32'h0, 24, ra, rb);
        xfer(32'h0, 16, ra, rb);
        cs_high();
        check("pd_read_oe", {31'd0, oe_seen}, 32'd0);
        check("pd_read_mem", mq_a.size() + mq_b.size(), 32'd0);
        check("pd_read_miso", ra | rb, 32'd0);

        command(32'hAB, 8);
        check("wake_pd", {30'd0, pd_a, pd_b}, 32'd0);
        do_read(24'h000010, 4);

        // JEDEC ID then zero padding, no memory traffic.
        mq_a.delete(); mq_b.delete();
        jedec = 24'hEF4016;
        cs_low();
        xfer(32'h9F, 8, ra, rb);
        for (int i = 0; i < 5; i++) begin
            xfer(32'h0, 8, ra, rb);
            check("id_a", ra, (i < 3) ? {24'h0, jedec[23 - 8*i -: 8]} : 32'h0);
            check("id_b", rb, (i < 3) ? {24'h0, jedec[23 - 8*i -: 8]} : 32'h0);
        end
        cs_high();
        check("id_mem", mq_a.size() + mq_b.size(), 32'd0);

        do_read(24'h00FFFF, 2);

        // Aborted address phase, then a clean read.
        mq_a.delete(); mq_b.delete();
        cs_low();
        xfer(32'h03, 8, ra, rb);
        xfer(32'h0, 12, ra, rb);
        cs_high();
        check("abort_mem", mq_a.size() + mq_b.size(), 32'd0);
        do_read(24'h000004, 1);

        for (int k = 0; k < 8; k++) begin
            do_read(24'($urandom), $urandom_range(1, 5));
        end

        command(32'hB9, 8);
        check("sleep_pd", {30'd0, pd_a, pd_b}, 32'd3);
        command({23'd0, 8'hAB, 1'b1}, 9);
        check("wake_void_pd", {30'd0, pd_a, pd_b}, 32'd3);
        command(32'hAB, 8);
        check("wake_again_pd", {30'd0, pd_a, pd_b}, 32'd0);

        // Reset in the middle of a data phase.
        cs_low();
        xfer(32'h03, 8, ra, rb);
        xfer(32'h000200, 24, ra, rb);
        xfer(32'h0, 8, ra, rb);
        xfer(32'h0, 3, ra, rb);
        reset = 1'b1;
        ticks(1);
        check("mid_rst_oe", {30'd0, oe_a, oe_b}, 32'd0);
        check("mid_rst_en", {30'd0, en_a, en_b}, 32'd0);
        check("mid_rst_pd", {30'd0, pd_a, pd_b}, 32'd3);
        ticks(1);
        reset = 1'b0;
        spi_sclk = 1'b0;
        ticks(6);
        spi_csb = 1'b1;
        ticks(8);

        check("invariants", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
